// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: word type, FSM state encoding and latency limits.
package rv32i_types;
   typedef logic [31:0] rv32i_word;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mem_resp_state_t;

   localparam int unsigned MEM_LAT_MAX = 15;

   // BUSY counts down to zero, so a request spends LATENCY-1 cycles there before RESP
   function automatic logic [3:0] mem_lat_load(input int unsigned lat);
      return (lat > 1) ? 4'(lat - 2) : 4'd0;
   endfunction
endpackage

// File: rtl/mem_responder_if.sv
// CPU-side memory request/response bundle; the CPU drives master, the responder is slave.
interface mem_responder_if;
   import rv32i_types::*;

   logic      mem_read;
   logic      mem_write;
   logic [3:0] mem_byte_enable;
   rv32i_word mem_address;
   rv32i_word mem_wdata;
   rv32i_word mem_rdata;
   logic      mem_resp;
   logic      mem_err;

   modport master (
      output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      input  mem_rdata, mem_resp, mem_err
   );

   modport slave (
      input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      output mem_rdata, mem_resp, mem_err
   );
endinterface

// File: rtl/mem_responder_array.sv
// Word-wide backing store: one synchronous port, registered read, byte-lane writes, no reset.
module mem_array
   import rv32i_types::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic             clk,
   input  logic             i_rd_en,
   input  logic             i_wr_en,
   input  logic [3:0]       i_be,
   input  logic [IDX_W-1:0] i_idx,
   input  rv32i_word        i_wdata,
   output rv32i_word        o_rdata
);
   rv32i_word r_mem [DEPTH_WORDS];
   rv32i_word r_rdata;

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
      if (i_rd_en) r_rdata <= r_mem[i_idx];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one request in IDLE, answers after LATENCY edges
// with a one-cycle mem_resp, flagging out-of-range and read+write requests as errors.
module mem_responder
   import rv32i_types::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 3
) (
   input logic             clk,
   input logic             rst,
   mem_responder_if.slave  bus
);
   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   mem_resp_state_t r_state, w_next;
   logic [3:0]      r_cnt;
   logic            r_rd, r_wr;
   logic [3:0]      r_be;
   logic [29:0]     r_waddr;
   rv32i_word       r_wdata;
   logic            r_err;
   logic            r_rzero;

   logic            w_req, w_accept, w_to_resp, w_err;
   logic            w_rd, w_wr, w_arr_rd, w_arr_wr;
   logic [3:0]      w_be;
   logic [29:0]     w_waddr;
   rv32i_word       w_wdata, w_arr_rdata;
   logic            w_unused_addr_lsb;

   assign w_unused_addr_lsb = ^bus.mem_address[1:0];
   assign w_req    = bus.mem_read | bus.mem_write;
   assign w_accept = (r_state == IDLE) && w_req;

   // With LATENCY=1 the commit happens on the accepting edge, so IDLE feeds live inputs through
   always_comb begin
      if (r_state == IDLE) begin
         w_rd    = bus.mem_read;
         w_wr    = bus.mem_write;
         w_be    = bus.mem_byte_enable;
         w_waddr = bus.mem_address[31:2];
         w_wdata = bus.mem_wdata;
      end else begin
         w_rd    = r_rd;
         w_wr    = r_wr;
         w_be    = r_be;
         w_waddr = r_waddr;
         w_wdata = r_wdata;
      end
   end

   assign w_err     = ({2'b00, w_waddr} >= DEPTH_WORDS) || (w_rd && w_wr);
   assign w_to_resp = (w_next == RESP);
   assign w_arr_rd  = !rst && w_to_resp && w_rd && !w_err;
   assign w_arr_wr  = !rst && w_to_resp && w_wr && !w_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_req) w_next = (LATENCY == 1) ? RESP : BUSY;
         BUSY:    if (r_cnt == 4'd0) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_resp  = (r_state == RESP);
      bus.mem_err   = (r_state == RESP) && r_err;
      bus.mem_rdata = r_rzero ? '0 : w_arr_rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                  r_cnt <= 4'd0;
      else if (w_accept)                        r_cnt <= mem_lat_load(LATENCY);
      else if (r_state == BUSY && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_rd    <= bus.mem_read;
         r_wr    <= bus.mem_write;
         r_be    <= bus.mem_byte_enable;
         r_waddr <= bus.mem_address[31:2];
         r_wdata <= bus.mem_wdata;
      end
   end

   // r_rzero masks the array read register, which has no reset, and zeroes error reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err   <= 1'b0;
         r_rzero <= 1'b1;
      end else if (w_to_resp) begin
         r_err <= w_err;
         if (w_err)     r_rzero <= 1'b1;
         else if (w_rd) r_rzero <= 1'b0;
      end
   end

   mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk     (clk),
      .i_rd_en (w_arr_rd),
      .i_wr_en (w_arr_wr),
      .i_be    (w_be),
      .i_idx   (w_waddr[IDX_W-1:0]),
      .i_wdata (w_wdata),
      .o_rdata (w_arr_rdata)
   );
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: a LATENCY=3 and a LATENCY=1 responder driven through their own bus bundles.
module tb_mem_responder;
   import rv32i_types::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;

   mem_responder_if if3 ();
   mem_responder_if if1 ();

   mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
   mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

   always #5 clk = ~clk;

   task automatic drive(input bit use1, input logic rd, input logic wr, input logic [3:0] be,
                        input rv32i_word a, input rv32i_word d);
      if3.mem_read = use1 ? 1'b0 : rd;   if1.mem_read = use1 ? rd : 1'b0;
      if3.mem_write = use1 ? 1'b0 : wr;  if1.mem_write = use1 ? wr : 1'b0;
      if3.mem_byte_enable = be;          if1.mem_byte_enable = be;
      if3.mem_address = a;               if1.mem_address = a;
      if3.mem_wdata = d;                 if1.mem_wdata = d;
   endtask

   // Issue one request and report edges-to-response (0 = none within budget) and the cycle after
   task automatic req(input bit use1, input logic rd, input logic wr, input logic [3:0] be,
                      input rv32i_word a, input rv32i_word d, input bit scramble,
                      output int lat, output rv32i_word rdata, output logic err,
                      output logic resp_after, output logic err_after);
      lat = 0; rdata = '0; err = 1'b0;
      @(negedge clk);
      drive(use1, rd, wr, be, a, d);
      @(posedge clk);
      #1 if (scramble) drive(use1, rd, wr, ~be, a ^ 32'h30, ~d);
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (use1 ? if1.mem_resp : if3.mem_resp) begin
            lat = n;
            rdata = use1 ? if1.mem_rdata : if3.mem_rdata;
            err = use1 ? if1.mem_err : if3.mem_err;
            break;
         end
         @(posedge clk);
      end
      drive(use1, 1'b0, 1'b0, 4'h0, '0, '0);
      @(negedge clk);
      resp_after = use1 ? if1.mem_resp : if3.mem_resp;
      err_after = use1 ? if1.mem_err : if3.mem_err;
   endtask

   int lat; rv32i_word rd; logic er, ra, ea;

   task automatic test_reset();
      #12;
      n_cmp++; if (if3.mem_resp !== 1'b0) begin n_fail++; $display("FAIL rst_resp: got %b want 0", if3.mem_resp); end
      n_cmp++; if (if3.mem_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", if3.mem_err); end
      n_cmp++; if (if3.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", if3.mem_rdata); end
      n_cmp++; if (if1.mem_resp !== 1'b0) begin n_fail++; $display("FAIL rst_resp1: got %b want 0", if1.mem_resp); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      req(0, 1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, lat, rd, er, ra, ea);
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL wr_lat: got %0d want 3", lat); end
      n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", er); end
      n_cmp++; if ({ra, ea} !== 2'b00) begin n_fail++; $display("FAIL wr_pulse: got %b want 00", {ra, ea}); end
      req(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 0, lat, rd, er, ra, ea);
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL rd_lat: got %0d want 3", lat); end
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", rd); end
      n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", er); end
      n_cmp++; if ({ra, ea} !== 2'b00) begin n_fail++; $display("FAIL rd_pulse: got %b want 00", {ra, ea}); end
   endtask

   task automatic test_byte_lanes();
      req(0, 1'b0, 1'b1, 4'b0001, 32'h10, 32'h000000AA, 0, lat, rd, er, ra, ea);
      n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_keeps_rdata: got %h want deadbeef", rd); end
      req(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 0, lat, rd, er, ra, ea);
      n_cmp++; if (rd !== 32'hDEADBEAA) begin n_fail++; $display("FAIL be_0001: got %h want deadbeaa", rd); end
      req(0, 1'b0, 1'b1, 4'b1100, 32'h10, 32'h12340000, 0, lat, rd, er, ra, ea);
      req(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 0, lat, rd, er, ra, ea);
      n_cmp++; if (rd !== 32'h1234BEAA) begin n_fail++; $display("FAIL be_1100: got %h want 1234beaa", rd); end
      req(0, 1'b0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 0, lat, rd, er, ra, ea);
      n_cmp++; if ({lat, er} !== {32'd3, 1'b0}) begin n_fail++; $display("FAIL be_0000_resp: got lat %0d err %b want 3 0", lat, er); end
      req(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 0, lat, rd, er, ra, ea);
      n_cmp++; if (rd !== 32'h1234BEAA) begin n_fail++; $display("FAIL be_0000: got %h want 1234beaa", rd); end
   endtask

   task automatic test_out_of_range();
      req(0, 1'b1, 1'b0, 4'h0, 32'h00001000, 32'h0, 0, lat, rd, er, ra, ea);
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL oor_lat: got %0d want 3", lat); end
      n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_err: got %b want 1", er); end
      n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_rdata: got %h want 0", rd); end
      n_cmp++; if (ea !== 1'b0) begin n_fail++; $display("FAIL oor_err_after: got %b want 0", ea); end
      req(0, 1'b0, 1'b1, 4'hF, 32'h00001010, 32'h99999999, 0, lat, rd, er, ra, ea);
      n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_wr_err: got %b want 1", er); end
      req(0, 1'b0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, 0, lat, rd, er, ra, ea);
      req(0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 0, lat, rd, er, ra, ea);
      n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL after_oor_err: got %b want 0", er); end
      n_cmp++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL after_oor_data: got %h want cafef00d", rd); end
      req(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 0, lat, rd, er, ra, ea);
      n_cmp++; if (rd !== 32'h1234BEAA) begin n_fail++; $display("FAIL oor_wr_alias: got %h want 1234beaa", rd); end
   endtask

   task automatic test_both();
      req(0, 1'b0, 1'b1, 4'hF, 32'h20, 32'h0BADCAFE, 0, lat, rd, er, ra, ea);
      req(0, 1'b1, 1'b1, 4'hF, 32'h20, 32'hFFFFFFFF, 0, lat, rd, er, ra, ea);
      n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL both_err: got %b want 1", er); end
      n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL both_rdata: got %h want 0", rd); end
      req(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0, 0, lat, rd, er, ra, ea);
      n_cmp++; if (rd !== 32'h0BADCAFE) begin n_fail++; $display("FAIL both_readback: got %h want 0badcafe", rd); end
   endtask

   task automatic test_inputs_ignored();
      req(0, 1'b0, 1'b1, 4'hF, 32'h10, 32'h0F0F0F0F, 1, lat, rd, er, ra, ea);
      req(0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1, lat, rd, er, ra, ea);
      n_cmp++; if (rd !== 32'h0F0F0F0F) begin n_fail++; $display("FAIL latched_inputs: got %h want 0f0f0f0f", rd); end
   endtask

   task automatic test_reset_busy();
      int seen = 0;
      req(0, 1'b0, 1'b1, 4'hF, 32'h40, 32'h11223344, 0, lat, rd, er, ra, ea);
      req(0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 0, lat, rd, er, ra, ea);
      @(negedge clk);
      drive(0, 1'b0, 1'b1, 4'hF, 32'h40, 32'h55555555);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (if3.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL async_rdata: got %h want 0", if3.mem_rdata); end
      drive(0, 1'b0, 1'b0, 4'h0, '0, '0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (if3.mem_resp) seen++;
      end
      n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort_resp: got %0d want 0", seen); end
      req(0, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0, 0, lat, rd, er, ra, ea);
      n_cmp++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL abort_nowrite: got %h want 11223344", rd); end
   endtask

   task automatic test_latency1();
      int pulses = 0;
      req(1, 1'b0, 1'b1, 4'hF, 32'h8, 32'h600DF00D, 0, lat, rd, er, ra, ea);
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL l1_wr_lat: got %0d want 1", lat); end
      req(1, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0, 0, lat, rd, er, ra, ea);
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL l1_rd_lat: got %0d want 1", lat); end
      n_cmp++; if (rd !== 32'h600DF00D) begin n_fail++; $display("FAIL l1_rd_data: got %h want 600df00d", rd); end
      @(negedge clk);
      drive(1, 1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         n_cmp++;
         if (if1.mem_resp !== ((k % 2) == 0)) begin
            n_fail++; $display("FAIL l1_held_k%0d: got %b want %b", k, if1.mem_resp, (k % 2) == 0);
         end
         if (if1.mem_resp) pulses++;
      end
      drive(1, 1'b0, 1'b0, 4'h0, '0, '0);
      n_cmp++; if (pulses !== 3) begin n_fail++; $display("FAIL l1_pulses: got %0d want 3", pulses); end
   endtask

   initial begin
      drive(0, 1'b0, 1'b0, 4'h0, '0, '0);
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_out_of_range();
      test_both();
      test_inputs_ignored();
      test_reset_busy();
      test_latency1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the backing array.
REQ-002 Parameter LATENCY, default 3, cycles from request acceptance to response; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 mem_read  input  1  read request from the CPU, held until mem_resp.
REQ-006 mem_write  input  1  write request from the CPU, held until mem_resp.
REQ-007 mem_byte_enable  input  4  write lane mask; bit i enables byte i of mem_wdata.
REQ-008 mem_address  input  32  byte address; bits [1:0] are ignored for array indexing.
REQ-009 mem_wdata  input  32  write data.
REQ-010 mem_rdata  output  32  read data, valid while mem_resp=1.
REQ-011 mem_resp  output  1  one-cycle completion pulse.
REQ-012 mem_err  output  1  error flag, valid only while mem_resp=1.

Function
REQ-013 FSM states are IDLE, BUSY and RESP.
REQ-014 In IDLE, mem_read or mem_write high at a rising edge accepts the request, which latches mem_address, mem_wdata, mem_byte_enable and the operation.
REQ-015 When LATENCY=1, an accepted request goes IDLE->RESP; otherwise it goes IDLE->BUSY with the counter loaded to LATENCY-2.
REQ-016 BUSY decrements the counter each cycle and moves to RESP at count 0.
REQ-017 mem_resp is 1 exactly in RESP, i.e. the cycle starting LATENCY edges after acceptance.
REQ-018 RESP always returns to IDLE next edge; a request sampled in RESP is not accepted (no back-to-back accept in the RESP cycle).
REQ-019 Inputs changing during BUSY/RESP have no effect; only latched values are used.
REQ-020 Read: at the edge entering RESP, mem_rdata is loaded with array[latched_addr[31:2]]; mem_rdata holds that value until the next response.
REQ-021 Write: at the edge entering RESP, each byte lane i with latched mbe[i]=1 is updated; lanes with mbe[i]=0 are unchanged; mem_rdata is unchanged.
REQ-022 Write with mbe=4'b0000 completes normally with no array change.
REQ-023 Out of range: when latched_addr[31:2] >= DEPTH_WORDS, the request completes with the same latency, mem_err=1, mem_rdata=0 and no array write.
REQ-024 Simultaneous mem_read and mem_write at acceptance completes with mem_err=1, mem_rdata=0 and no array write.
REQ-025 mem_err=0 whenever mem_resp=0.

Reset
REQ-026 Asserting rst forces state to IDLE, counter to 0, mem_resp=0, mem_err=0 and mem_rdata=32'h0 immediately, without waiting for clk.
REQ-027 Reset leaves array contents unchanged.
REQ-028 Reset during BUSY aborts the request: no write is committed and no response is issued.
REQ-029 The first acceptance after reset is possible on the first rising edge with rst low.

Structure
REQ-030 The state enum mem_resp_state_t and the constant MEM_LAT_MAX=15 reside in the shared rv32i_types package; addresses and data use rv32i_word.
REQ-031 Storage is one sub-module, mem_array, with one synchronous read/byte-enabled write port, DEPTH_WORDS deep and no reset.
REQ-032 The FSM, counter and error detection reside in mem_responder.

Verification
REQ-033 LATENCY=3, write addr 0x10, data 0xDEADBEEF, mbe 4'hF, then read 0x10 -> each mem_resp comes 3 edges after acceptance, for 1 cycle; mem_rdata=0xDEADBEEF.
REQ-034 Array word 0x10=0xDEADBEEF, write data 0x000000AA, mbe 4'b0001, then read -> mem_rdata=0xDEADBEAA; then mbe 4'b1100, data 0x12340000, read -> 0x1234BEAA.
REQ-035 DEPTH_WORDS=1024, read addr 0x00001000 -> mem_resp with mem_err=1, mem_rdata=0; a following read of 0x0 returns a normal response with mem_err=0.
REQ-036 mem_read and mem_write both high at addr 0x20 -> mem_err=1, word 0x20 unchanged on readback.
REQ-037 Write 0x55555555 to 0x40 with rst pulsed in BUSY -> mem_resp never asserts; a later read of 0x40 returns the prior value.
REQ-038 LATENCY=1, CPU holds mem_read through RESP -> exactly one mem_resp per accepted request; re-acceptance occurs in the cycle after RESP.
